// File: rtl/usr_sw_led_ctrl.sv
// usr_sw_led_ctrl: debounced DIP-switch capture with change events and a multi-mode LED driver
module usr_sw_led_ctrl #(
  parameter int NSW = 8,
  parameter int NLED = 8,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int BLINK_LOG2 = 24,
  parameter bit LED_ACTIVE_LOW = 1'b0
) (
  input  logic            sys0_clk,
  input  logic            sys0_rst,
  input  logic [NSW-1:0]  usr_sw_i,
  input  logic [1:0]      led_mode,
  input  logic [NLED-1:0] led_val,
  input  logic            sw_ack,
  output logic [NLED-1:0] led,
  output logic [NSW-1:0]  sw_q,
  output logic            sw_chg_valid,
  output logic [NSW-1:0]  sw_chg_mask
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = BLINK_LOG2 + NLED;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [NLED-1:0] LED_INV = {NLED{LED_ACTIVE_LOW}};
  logic [NSW-1:0] sync1_q, sync2_q, sw_d, upd_q, upd_d, chg_mask_q, chg_mask_d;
  logic [NSW-1:0][CW-1:0] cnt_q, cnt_d;
  logic chg_valid_q, chg_valid_d;
  logic [HW-1:0] hb_cnt_q, hb_cnt_d;
  logic [NLED-1:0] led_q, led_d, sw_led;
  always_comb begin
    sw_d = sw_q;
    upd_d = '0;
    cnt_d = '0;
    for (int i = 0; i < NSW; i++) begin
      if (sync2_q[i] != sw_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          sw_d[i] = sync2_q[i];
          upd_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end
  // Events are raised from the registered update so they trail the sw_q change by one cycle
  always_comb begin
    chg_valid_d = (|upd_q) | (chg_valid_q & ~sw_ack);
    chg_mask_d = (sw_ack ? '0 : chg_mask_q) | upd_q;
    hb_cnt_d = hb_cnt_q + HW'(1);
  end
  always_comb begin
    sw_led = '0;
    for (int i = 0; i < NLED && i < NSW; i++) sw_led[i] = sw_q[i];
    led_d = LED_INV ^ (led_mode == 2'b00 ? led_val :
                       led_mode == 2'b01 ? (led_val & {NLED{hb_cnt_q[BLINK_LOG2-1]}}) :
                       led_mode == 2'b10 ? sw_led : hb_cnt_q[BLINK_LOG2 +: NLED]);
  end
  always_ff @(posedge sys0_clk) begin
    if (sys0_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q <= '0;
      sw_q <= '0;
      upd_q <= '0;
      chg_valid_q <= 1'b0;
      chg_mask_q <= '0;
      hb_cnt_q <= '0;
      led_q <= LED_INV;
    end else begin
      sync1_q <= usr_sw_i;
      sync2_q <= sync1_q;
      cnt_q <= cnt_d;
      sw_q <= sw_d;
      upd_q <= upd_d;
      chg_valid_q <= chg_valid_d;
      chg_mask_q <= chg_mask_d;
      hb_cnt_q <= hb_cnt_d;
      led_q <= led_d;
    end
  end
  assign led = led_q;
  assign sw_chg_valid = chg_valid_q;
  assign sw_chg_mask = chg_mask_q;
endmodule

// File: tb/tb_usr_sw_led_ctrl.sv
// tb_usr_sw_led_ctrl: directed vector table, reset corner sequences and a randomized run against a behavioural model
module tb_usr_sw_led_ctrl;
  localparam int D = 4;
  localparam int NV = 20;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rst2, ack, valid, valid2;
  logic [1:0] mode, mode2;
  logic [7:0] sw, val, val2, led, led2, swq, swq2, mask, mask2;
  int errors = 0, checks = 0;

  usr_sw_led_ctrl #(.NSW(8), .NLED(8), .DEBOUNCE_CYC(D), .BLINK_LOG2(3), .LED_ACTIVE_LOW(1'b0)) dut (
    .sys0_clk(clk), .sys0_rst(rst), .usr_sw_i(sw), .led_mode(mode), .led_val(val), .sw_ack(ack),
    .led(led), .sw_q(swq), .sw_chg_valid(valid), .sw_chg_mask(mask));
  usr_sw_led_ctrl #(.NSW(8), .NLED(8), .DEBOUNCE_CYC(D), .BLINK_LOG2(3), .LED_ACTIVE_LOW(1'b1)) dut_al (
    .sys0_clk(clk), .sys0_rst(rst2), .usr_sw_i(sw), .led_mode(mode2), .led_val(val2), .sw_ack(ack),
    .led(led2), .sw_q(swq2), .sw_chg_valid(valid2), .sw_chg_mask(mask2));

  typedef struct {
    logic rst; logic [7:0] sw; logic [1:0] mode; logic [7:0] val; logic ack; int ncyc;
    logic [7:0] e_led; logic [7:0] e_sw; logic e_v; logic [7:0] e_m;
  } vec_t;
  vec_t tbl [NV];

  // behavioural model state: value each output will hold after the next rising edge
  logic [7:0] m_s1, m_s2, m_sw, m_upd, m_mask, m_led;
  logic m_valid;
  int m_hb, hfill;
  logic [7:0] hist [D];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int idx, input logic [7:0] e_led, input logic [7:0] e_sw,
                         input logic e_v, input logic [7:0] e_m);
    chk({name, "_led"}, idx, 32'(led), 32'(e_led));
    chk({name, "_sw_q"}, idx, 32'(swq), 32'(e_sw));
    chk({name, "_valid"}, idx, 32'(valid), 32'(e_v));
    chk({name, "_mask"}, idx, 32'(mask), 32'(e_m));
  endtask

  // A switch bit is accepted once its last D synchronised samples all disagree with the held value
  task automatic model_step();
    logic [7:0] upd;
    bit all_diff;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_sw = 0; m_upd = 0; m_valid = 0; m_mask = 0; m_hb = 0; m_led = 0; hfill = 0;
      return;
    end
    m_led = mode == 2'd0 ? val : mode == 2'd1 ? (((m_hb >> 2) & 1) != 0 ? val : 8'h00) :
            mode == 2'd2 ? m_sw : 8'((m_hb >> 3) & 255);
    for (int j = D - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = m_s2;
    if (hfill < D) hfill++;
    upd = 0;
    if (hfill == D)
      for (int b = 0; b < 8; b++) begin
        all_diff = 1;
        for (int j = 0; j < D; j++) if (hist[j][b] == m_sw[b]) all_diff = 0;
        upd[b] = all_diff;
      end
    if (m_upd != 0) begin
      m_valid = 1;
      m_mask = ack ? m_upd : (m_mask | m_upd);
    end else if (ack) begin
      m_valid = 0;
      m_mask = 0;
    end
    m_sw = m_sw ^ upd;
    m_upd = upd;
    m_s2 = m_s1;
    m_s1 = sw;
    m_hb = (m_hb + 1) % 2048;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h00, 2'd0, 8'h3C, 1'b0, 1,    8'h3C ^ 8'h3C, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h05, 2'd0, 8'h3C, 1'b0, 5,    8'h3C, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h05, 2'd0, 8'h3C, 1'b0, 1,    8'h3C, 8'h05, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'h05, 2'd0, 8'h3C, 1'b0, 1,    8'h3C, 8'h05, 1'b1, 8'h05};
    tbl[4]  = '{1'b0, 8'h05, 2'd0, 8'h3C, 1'b1, 1,    8'h3C, 8'h05, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 8'h07, 2'd0, 8'h3C, 1'b0, 3,    8'h3C, 8'h05, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 8'h05, 2'd0, 8'h3C, 1'b0, 6,    8'h3C, 8'h05, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 8'h04, 2'd0, 8'h3C, 1'b0, 1,    8'h3C, 8'h05, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 8'h84, 2'd0, 8'h3C, 1'b0, 6,    8'h3C, 8'h84, 1'b1, 8'h01};
    tbl[9]  = '{1'b0, 8'h84, 2'd0, 8'h3C, 1'b1, 1,    8'h3C, 8'h84, 1'b1, 8'h80};
    tbl[10] = '{1'b0, 8'h84, 2'd0, 8'h3C, 1'b1, 1,    8'h3C, 8'h84, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 8'h84, 2'd1, 8'hA5, 1'b0, 1,    8'h00, 8'h84, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 8'h84, 2'd1, 8'hA5, 1'b0, 2,    8'hA5, 8'h84, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 8'h84, 2'd1, 8'hA5, 1'b0, 4,    8'h00, 8'h84, 1'b0, 8'h00};
    tbl[14] = '{1'b0, 8'h84, 2'd1, 8'hA5, 1'b0, 4,    8'hA5, 8'h84, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 8'h84, 2'd3, 8'hA5, 1'b0, 3,    8'h04, 8'h84, 1'b0, 8'h00};
    tbl[16] = '{1'b0, 8'h84, 2'd3, 8'hA5, 1'b0, 8,    8'h05, 8'h84, 1'b0, 8'h00};
    tbl[17] = '{1'b0, 8'h84, 2'd3, 8'hA5, 1'b0, 2000, 8'hFF, 8'h84, 1'b0, 8'h00};
    tbl[18] = '{1'b0, 8'h84, 2'd3, 8'hA5, 1'b0, 1,    8'h00, 8'h84, 1'b0, 8'h00};
    tbl[19] = '{1'b0, 8'h84, 2'd2, 8'hA5, 1'b0, 1,    8'h84, 8'h84, 1'b0, 8'h00};

    rst = 1; rst2 = 1; ack = 0; sw = 0; mode = 0; val = 8'h3C; mode2 = 0; val2 = 8'h0F;
    m_s1 = 0; m_s2 = 0; m_sw = 0; m_upd = 0; m_valid = 0; m_mask = 0; m_hb = 0; m_led = 0; hfill = 0;
    repeat (3) @(negedge clk);
    chk("al_reset_led", 0, 32'(led2), 32'hFF);
    rst2 = 0;
    @(negedge clk);
    chk("al_direct_led", 0, 32'(led2), 32'hF0);

    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; sw = tbl[i].sw; mode = tbl[i].mode; val = tbl[i].val; ack = tbl[i].ack;
      repeat (tbl[i].ncyc) @(negedge clk);
      chk_all("vec", i, tbl[i].e_led, tbl[i].e_sw, tbl[i].e_v, tbl[i].e_m);
    end

    // reset lands two counts into a debounce; the partial count must be thrown away
    rst = 1; ack = 0; sw = 0; mode = 0; val = 8'h00;
    repeat (2) @(negedge clk);
    rst = 0; sw = 8'h01;
    repeat (4) @(negedge clk);
    chk("mid_pre", 0, 32'(swq), 32'h00);
    rst = 1; ack = 1;
    repeat (2) @(negedge clk);
    chk_all("mid_rst", 0, 8'h00, 8'h00, 1'b0, 8'h00);
    rst = 0; ack = 0;
    repeat (5) @(negedge clk);
    chk("mid_wait", 0, 32'(swq), 32'h00);
    @(negedge clk);
    chk("mid_accept", 0, 32'(swq), 32'h01);
    @(negedge clk);
    chk("mid_evt_valid", 0, 32'(valid), 32'h1);
    chk("mid_evt_mask", 0, 32'(mask), 32'h01);

    for (int c = 0; c < 3000; c++) begin
      rst = (c < 2) || ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) sw = sw ^ (8'h01 << $urandom_range(0, 7));
      ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        mode = 2'($urandom_range(0, 3));
        val = 8'($urandom);
      end
      model_step();
      @(negedge clk);
      if (c >= 2) chk_all("rnd", c, m_led, m_sw, m_valid, m_mask);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
